// File: rtl/i3c_pkg.sv
// Shared types for the I3C APB requester: FSM state encoding and request record layout.
package i3c_pkg;

  localparam int unsigned I3C_APB_AW = 32;
  localparam int unsigned I3C_APB_DW = 32;
  localparam int unsigned I3C_APB_SW = I3C_APB_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } i3c_apb_req_state_e;

  typedef struct packed {
    logic                  write;
    logic [I3C_APB_AW-1:0] addr;
    logic [I3C_APB_DW-1:0] wdata;
    logic [I3C_APB_SW-1:0] strb;
  } i3c_apb_req_t;

  // Width of one flattened request entry {write, addr, wdata, strb}.
  function automatic int unsigned apb_req_bits(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw + (dw / 8);
  endfunction

endpackage

// File: rtl/i3c_apb_req_fifo.sv
// Synchronous request FIFO; extra pointer MSB distinguishes full from empty.
module i3c_apb_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [Width-1:0] r_mem [Depth];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/i3c_apb_requester.sv
// APB4 manager driving the I3C core register port from a buffered request stream.
// Optional ACCESS-phase timeout: define I3C_APB_REQUESTER_TIMEOUT_EN.
module i3c_apb_requester
  import i3c_pkg::*;
#(
  parameter int unsigned ApbAddrWidth  = 32,
  parameter int unsigned ApbDataWidth  = 32,
  parameter int unsigned ReqDepth      = 4,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [ApbAddrWidth-1:0]   req_addr_i,
  input  logic [ApbDataWidth-1:0]   req_wdata_i,
  input  logic [ApbDataWidth/8-1:0] req_strb_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ApbDataWidth-1:0]   rsp_rdata_o,
  output logic                      rsp_slverr_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ApbAddrWidth-1:0]   paddr_o,
  output logic [ApbDataWidth-1:0]   pwdata_o,
  output logic [ApbDataWidth/8-1:0] pstrb_o,
  input  logic [ApbDataWidth-1:0]   prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int unsigned StrbW  = ApbDataWidth / 8;
  localparam int unsigned EntryW = apb_req_bits(ApbAddrWidth, ApbDataWidth);

  i3c_apb_req_state_e      r_state;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ApbAddrWidth-1:0] r_paddr;
  logic [ApbDataWidth-1:0] r_pwdata;
  logic [StrbW-1:0]        r_pstrb;
  logic                    r_rsp_valid;
  logic [ApbDataWidth-1:0] r_rsp_rdata;
  logic                    r_rsp_slverr;

  logic [EntryW-1:0]       w_push_data;
  logic [EntryW-1:0]       w_head;
  logic                    w_head_write;
  logic [ApbAddrWidth-1:0] w_head_addr;
  logic [ApbDataWidth-1:0] w_head_wdata;
  logic [StrbW-1:0]        w_head_strb;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;

  assign w_push_data = {req_write_i, req_addr_i, req_wdata_i, req_strb_i};
  assign {w_head_write, w_head_addr, w_head_wdata, w_head_strb} = w_head;
  assign req_ready_o = !w_full;
  assign w_push      = req_valid_i && !w_full;
  // Pop from IDLE, or straight out of RESP on handshake for back-to-back transfers.
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_RESP) && rsp_ready_i));

  i3c_apb_req_fifo #(
    .Width (EntryW),
    .Depth (ReqDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef I3C_APB_REQUESTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_inc;
  logic            r_rsp_timeout;
  assign w_cnt_inc     = r_cnt + CntW'(1);
  assign rsp_timeout_o = r_rsp_timeout;
`else
  localparam int unsigned unused_timeout_cycles = TimeoutCycles;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
`ifdef I3C_APB_REQUESTER_TIMEOUT_EN
      r_cnt         <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
`ifdef I3C_APB_REQUESTER_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        ST_ACCESS: begin
          if (pready_i) begin
            r_rsp_rdata  <= r_pwrite ? '0 : prdata_i;
            r_rsp_slverr <= pslverr_i;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
`ifdef I3C_APB_REQUESTER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
          end else if (w_cnt_inc == CntW'(TimeoutCycles)) begin
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: ;
      endcase
      // A pop overrides the state chosen above and starts the next SETUP.
      if (w_pop) begin
        r_pwrite  <= w_head_write;
        r_paddr   <= w_head_addr;
        r_pwdata  <= w_head_wdata;
        r_pstrb   <= w_head_write ? w_head_strb : '0;
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_state   <= ST_SETUP;
      end
    end
  end

  assign psel_o       = r_psel;
  assign penable_o    = r_penable;
  assign pwrite_o     = r_pwrite;
  assign paddr_o      = r_paddr;
  assign pwdata_o     = r_pwdata;
  assign pstrb_o      = r_pstrb;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_rdata_o  = r_rsp_rdata;
  assign rsp_slverr_o = r_rsp_slverr;
  assign busy_o       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: doc/i3c_apb_requester.md
Name: i3c_apb_requester

Overview:
APB4 manager (requester) that drives the APB4 subordinate port of the I3C core.
- Accepts register read/write requests on a valid/ready stream and buffers them in a small FIFO.
- Executes each request as an APB4 SETUP/ACCESS transfer and returns read data and error status on a response stream.
- Sits between a firmware/sequencer command source and the I3C core's psel/penable/pwrite/paddr/pwdata/pstrb/prdata/pready/pslverr interface.

Parameters:
ApbAddrWidth, 32, APB address width
ApbDataWidth, 32, APB data width; multiple of 8
ReqDepth, 4, request FIFO depth; power of two, >= 2
TimeoutCycles, 256, ACCESS-phase cycle limit; used only when the optional feature is enabled

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high with req_valid_i; equals FIFO not full
req_write_i  in  1  1 = write, 0 = read
req_addr_i  in  ApbAddrWidth  register byte address
req_wdata_i  in  ApbDataWidth  write data
req_strb_i  in  ApbDataWidth/8  write strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_rdata_o  out  ApbDataWidth  read data; 0 for writes
rsp_slverr_o  out  1  subordinate returned pslverr
rsp_timeout_o  out  1  transfer aborted by timeout
busy_o  out  1  FSM not IDLE or FIFO not empty
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  ApbAddrWidth  APB address
pwdata_o  out  ApbDataWidth  APB write data
pstrb_o  out  ApbDataWidth/8  APB strobes
prdata_i  in  ApbDataWidth  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB error

Behaviour:
Reset values:
- All outputs 0, except req_ready_o = 1.
- FIFO empty; FSM in IDLE.

FIFO:
- Push on req_valid_i && req_ready_o.
- Pointers are log2(ReqDepth)+1 bits; full/empty are derived from the MSB compare.
- Simultaneous push and pop while full is not permitted: ready is low while full.

FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: when the FIFO is not empty, pop the head, latch it into the APB output registers, and go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1, with paddr/pwrite/pwdata/pstrb held stable. Stay until pready_i=1.
- On pready_i=1 in ACCESS:
  - capture rsp_rdata = prdata_i for reads, 0 for writes;
  - capture rsp_slverr = pslverr_i;
  - drop psel and penable;
  - go to RESP.
- RESP: rsp_valid_o=1, with all response fields held stable until rsp_ready_i.
  - On handshake, if the FIFO is not empty, pop and go directly to SETUP (back-to-back).
  - Otherwise go to IDLE.

Output conventions:
- For reads, pstrb_o is forced to 0 (APB4 rule). For writes, req_strb_i is passed as-is.
- A write with an all-zero strobe still issues a transfer.
- psel_o and penable_o are registered. penable_o is never high without psel_o.

Latency:
- Request handshake at edge N → SETUP in cycle N+2 (one cycle for FIFO visibility and pop).
- With pready held high: ACCESS in N+3, rsp_valid_o in N+4.
- Sustained throughput with rsp_ready_i tied high: one transfer per 3 cycles.

Boundary conditions:
- pready_i is ignored outside ACCESS.
- pslverr_i is sampled only with pready_i.
- Responses are returned strictly in request order.
- Reset mid-transfer: psel/penable drop asynchronously, the FIFO is flushed, and the in-flight response is discarded.

Optional Feature:
Macro: I3C_APB_REQUESTER_TIMEOUT_EN
Enabled:
- A counter (width $clog2(TimeoutCycles+1)) clears on SETUP→ACCESS and increments each ACCESS cycle without pready.
- When it reaches TimeoutCycles, the FSM drops psel/penable and goes to RESP with rsp_timeout_o=1, rsp_slverr_o=0, rsp_rdata_o=0.
- If pready_i arrives in the same cycle the limit is reached, pready wins: normal completion, no timeout.
Disabled:
- No counter; ACCESS waits indefinitely.
- rsp_timeout_o tied to 0; TimeoutCycles unused.

Decomposition:
i3c_pkg gains:
- the FSM state enum typedef i3c_apb_req_state_e;
- the packed request struct i3c_apb_req_t {write, addr, wdata, strb}, parameterised via package localparams for the default 32/32 widths.

Sub-module: i3c_apb_req_fifo. Synchronous FIFO with push/pop/full/empty and registered storage, instantiated once.

Test Plan:
- Single read: req {read, addr 0x0000_0100}; subordinate pready=1 in its first ACCESS cycle, prdata=0xDEAD_BEEF → psel/penable SETUP→ACCESS pattern; rsp_rdata=0xDEAD_BEEF, slverr=0, rsp_valid at N+4; pstrb_o=0 throughout.
- Write with wait states: req {write, addr 0x0000_0010, wdata 0x1234_5678, strb 0xF}; pready low for 3 ACCESS cycles → paddr/pwdata/pstrb stable for 4 ACCESS cycles; one response with rdata=0.
- Back-to-back plus backpressure: push 5 requests with ReqDepth=4 and rsp_ready low → req_ready_o low after the 4th queued entry (one entry in flight); responses arrive in order once rsp_ready rises; RESP→SETUP with no IDLE cycle.
- Error: pslverr=1 with pready on a read of 0x0000_0FFC → rsp_slverr_o=1; next request unaffected.
- Timeout (macro on, TimeoutCycles=8): pready held low → psel drops after 8 ACCESS cycles; rsp_timeout_o=1, rdata=0. Macro off: no response after 1000 cycles.
- Reset mid-ACCESS with 2 entries queued → psel_o=0 immediately; after reset, busy_o=0, req_ready_o=1, no stale response.
